issue_queue: RTL and testbench

//   Buffered, parametrised issue stage. Holds fetched instructions in an IQ_DEPTH-entry circular queue.

---
 rtl/issue_queue_pkg.sv | 78 +++++++
 rtl/issue_queue_if.sv | 46 ++++
 rtl/issue_queue_inst_decoder.sv | 131 +++++++++++++
 rtl/issue_queue.sv | 168 ++++++++++++++++
 tb/tb_issue_queue.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared op-type codes, instruction-class encodings and RV32I opcode fields for the issue stage.
package issue_queue_pkg;

  localparam int OP_W = 6;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_BR,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_UPPER
  } op_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Codes are grouped by class so the class can be recovered from ranges.
  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    if (op == OP_NOP)                       c = CLS_NONE;
    else if (op == OP_LUI || op == OP_AUIPC) c = CLS_UPPER;
    else if (op == OP_JAL || op == OP_JALR)  c = CLS_JUMP;
    else if (op <= OP_BGEU)                  c = CLS_BR;
    else if (op <= OP_LHU)                   c = CLS_LOAD;
    else if (op <= OP_SW)                    c = CLS_STORE;
    else                                     c = CLS_ALU;
    return c;
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side, stall/flush and dispatch bundle of the issue queue.
// master = issue queue, slave = surrounding pipeline.
interface issue_queue_if #(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_DEPTH = 16
);
  import issue_queue_pkg::*;

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
  localparam int ROB_W = $clog2(ROB_DEPTH);

  logic             inst_valid;
  logic [31:0]      inst_from_if;
  logic [31:0]      pc_from_if;
  logic             iq_full;
  logic [CNT_W-1:0] iq_count;
  logic             flush;
  logic [ROB_W-1:0] flush_tag;
  logic             rob_full;
  logic             rs_full;
  logic             lsb_full;
  logic [OP_W-1:0]  op_out;
  logic [4:0]       rd_out;
  logic [4:0]       rs1_idx;
  logic [4:0]       rs2_idx;
  logic [31:0]      imm_out;
  logic [31:0]      pc_out;
  logic [ROB_W-1:0] rob_tag;
  logic             rob_send_enable;
  logic             rs_send_enable;
  logic             lsb_send_enable;

  modport master (
    input  inst_valid, inst_from_if, pc_from_if, flush, flush_tag,
           rob_full, rs_full, lsb_full,
    output iq_full, iq_count, op_out, rd_out, rs1_idx, rs2_idx, imm_out,
           pc_out, rob_tag, rob_send_enable, rs_send_enable, lsb_send_enable
  );

  modport slave (
    output inst_valid, inst_from_if, pc_from_if, flush, flush_tag,
           rob_full, rs_full, lsb_full,
    input  iq_full, iq_count, op_out, rd_out, rs1_idx, rs2_idx, imm_out,
           pc_out, rob_tag, rob_send_enable, rs_send_enable, lsb_send_enable
  );
endinterface

// File: rtl/issue_queue_inst_decoder.sv
// Combinational RV32I decoder: op type, register indices (0 when unused), sign-extended immediate.
// Unknown or malformed encodings decode as OP_NOP with all fields zero and route to the RS.
module inst_decoder
  import issue_queue_pkg::*;
(
  input  logic [31:0]     inst,
  output logic [OP_W-1:0] op_type,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic            is_mem
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [OP_W-1:0] op;
  logic [31:0]     imm_raw;
  logic            use_rd, use_rs1, use_rs2;
  op_class_t       cls;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // Immediate shifts carry only the shift amount.
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    op      = OP_NOP;
    imm_raw = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_LUI: begin
        op = OP_LUI; imm_raw = imm_u; use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op = OP_AUIPC; imm_raw = imm_u; use_rd = 1'b1;
      end
      OPC_JAL: begin
        op = OP_JAL; imm_raw = imm_j; use_rd = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) op = OP_JALR;
        imm_raw = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_NOP;
        endcase
        imm_raw = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_NOP;
        endcase
        imm_raw = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_NOP;
        endcase
        imm_raw = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        case (f3)
          3'b000:  op = OP_ADDI;
          3'b010:  op = OP_SLTI;
          3'b011:  op = OP_SLTIU;
          3'b100:  op = OP_XORI;
          3'b110:  op = OP_ORI;
          3'b111:  op = OP_ANDI;
          3'b001:  op = (f7 == 7'b0000000) ? OP_SLLI : OP_NOP;
          default: op = (f7 == 7'b0000000) ? OP_SRLI :
                        (f7 == 7'b0100000) ? OP_SRAI : OP_NOP;
        endcase
        imm_raw = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OP: begin
        case ({f7, f3})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_110: op = OP_OR;
          10'b0000000_111: op = OP_AND;
          default:         op = OP_NOP;
        endcase
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: op = OP_NOP;
    endcase
  end

  assign cls     = op_class(op);
  assign op_type = op;
  assign rd      = (use_rd  && cls != CLS_NONE) ? inst[11:7]  : 5'd0;
  assign rs1     = (use_rs1 && cls != CLS_NONE) ? inst[19:15] : 5'd0;
  assign rs2     = (use_rs2 && cls != CLS_NONE) ? inst[24:20] : 5'd0;
  assign imm     = (cls != CLS_NONE) ? imm_raw : 32'd0;
  assign is_mem  = (cls == CLS_LOAD) || (cls == CLS_STORE);

endmodule

// File: rtl/issue_queue.sv
// Circular instruction queue that decodes its head and dispatches one instruction per cycle to RS/LSB with a ROB tag.
// Optional same-cycle dispatch of an instruction arriving at an empty queue: define ISSUE_BYPASS_EN.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  issue_queue_if.master bus
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(IQ_DEPTH);

  logic [31:0]      inst_mem [IQ_DEPTH];
  logic [31:0]      pc_mem   [IQ_DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ROB_W-1:0] tag_reg;

  logic [OP_W-1:0]  op_reg;
  logic [4:0]       rd_reg, rs1_reg, rs2_reg;
  logic [31:0]      imm_reg, pc_reg;
  logic [ROB_W-1:0] rob_tag_reg;
  logic             rob_send_reg, rs_send_reg, lsb_send_reg;

  logic [31:0]      head_inst, head_pc;
  logic [OP_W-1:0]  hd_op;
  logic [4:0]       hd_rd, hd_rs1, hd_rs2;
  logic [31:0]      hd_imm;
  logic             hd_is_mem;

  logic [OP_W-1:0]  sel_op;
  logic [4:0]       sel_rd, sel_rs1, sel_rs2;
  logic [31:0]      sel_imm, sel_pc;
  logic             sel_is_mem;

  logic             full, dispatch_q, bypass, fire, enq;

  assign head_inst = inst_mem[head_reg];
  assign head_pc   = pc_mem[head_reg];

  inst_decoder u_head_dec (
    .inst    (head_inst),
    .op_type (hd_op),
    .rd      (hd_rd),
    .rs1     (hd_rs1),
    .rs2     (hd_rs2),
    .imm     (hd_imm),
    .is_mem  (hd_is_mem)
  );

  assign full       = (count_reg == FULL_COUNT);
  assign dispatch_q = (count_reg != '0) && !bus.rob_full &&
                      (hd_is_mem ? !bus.lsb_full : !bus.rs_full);

`ifdef ISSUE_BYPASS_EN
  logic [OP_W-1:0] byp_op;
  logic [4:0]      byp_rd, byp_rs1, byp_rs2;
  logic [31:0]     byp_imm;
  logic            byp_is_mem;

  inst_decoder u_byp_dec (
    .inst    (bus.inst_from_if),
    .op_type (byp_op),
    .rd      (byp_rd),
    .rs1     (byp_rs1),
    .rs2     (byp_rs2),
    .imm     (byp_imm),
    .is_mem  (byp_is_mem)
  );

  // Only an empty queue may be bypassed, so ordering with queued entries is preserved.
  assign bypass     = (count_reg == '0) && bus.inst_valid && !bus.rob_full &&
                      (byp_is_mem ? !bus.lsb_full : !bus.rs_full);
  assign sel_op     = bypass ? byp_op     : hd_op;
  assign sel_rd     = bypass ? byp_rd     : hd_rd;
  assign sel_rs1    = bypass ? byp_rs1    : hd_rs1;
  assign sel_rs2    = bypass ? byp_rs2    : hd_rs2;
  assign sel_imm    = bypass ? byp_imm    : hd_imm;
  assign sel_pc     = bypass ? bus.pc_from_if : head_pc;
  assign sel_is_mem = bypass ? byp_is_mem : hd_is_mem;
`else
  assign bypass     = 1'b0;
  assign sel_op     = hd_op;
  assign sel_rd     = hd_rd;
  assign sel_rs1    = hd_rs1;
  assign sel_rs2    = hd_rs2;
  assign sel_imm    = hd_imm;
  assign sel_pc     = head_pc;
  assign sel_is_mem = hd_is_mem;
`endif

  assign fire = dispatch_q || bypass;
  assign enq  = bus.inst_valid && (!full || dispatch_q) && !bypass;

  always_ff @(posedge clk) begin
    if (rdy && !bus.flush && enq) begin
      inst_mem[tail_reg] <= bus.inst_from_if;
      pc_mem[tail_reg]   <= bus.pc_from_if;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      tag_reg      <= '0;
      op_reg       <= '0;
      rd_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      imm_reg      <= '0;
      pc_reg       <= '0;
      rob_tag_reg  <= '0;
      rob_send_reg <= 1'b0;
      rs_send_reg  <= 1'b0;
      lsb_send_reg <= 1'b0;
    end else if (rdy) begin
      if (bus.flush) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
        tag_reg      <= bus.flush_tag;
        rob_send_reg <= 1'b0;
        rs_send_reg  <= 1'b0;
        lsb_send_reg <= 1'b0;
      end else begin
        if (enq)        tail_reg <= tail_reg + PTR_W'(1);
        if (dispatch_q) head_reg <= head_reg + PTR_W'(1);
        count_reg    <= count_reg + CNT_W'(enq) - CNT_W'(dispatch_q);
        rob_send_reg <= fire;
        rs_send_reg  <= fire && !sel_is_mem;
        lsb_send_reg <= fire && sel_is_mem;
        if (fire) begin
          op_reg      <= sel_op;
          rd_reg      <= sel_rd;
          rs1_reg     <= sel_rs1;
          rs2_reg     <= sel_rs2;
          imm_reg     <= sel_imm;
          pc_reg      <= sel_pc;
          rob_tag_reg <= tag_reg;
          tag_reg     <= tag_reg + ROB_W'(1);
        end
      end
    end
  end

  assign bus.iq_full         = full;
  assign bus.iq_count        = count_reg;
  assign bus.op_out          = op_reg;
  assign bus.rd_out          = rd_reg;
  assign bus.rs1_idx         = rs1_reg;
  assign bus.rs2_idx         = rs2_reg;
  assign bus.imm_out         = imm_reg;
  assign bus.pc_out          = pc_reg;
  assign bus.rob_tag         = rob_tag_reg;
  assign bus.rob_send_enable = rob_send_reg;
  assign bus.rs_send_enable  = rs_send_reg;
  assign bus.lsb_send_enable = lsb_send_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: decode table through a dispatch scoreboard plus latency, stall, full, flush and reset sequences.
module tb_issue_queue;
  import issue_queue_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        is_mem;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic [3:0]  tag;
    logic        is_mem;
  } exp_t;

  localparam int NVEC = 13;

  logic  clk, rst, rdy;
  vec_t  vecs [NVEC];
  exp_t  exp_q [$];
  exp_t  mon_e;
  logic [3:0] tb_tag;
  int    n_pass, n_total;

  issue_queue_if #(.IQ_DEPTH(8), .ROB_DEPTH(16)) bus ();

  issue_queue #(.IQ_DEPTH(8), .ROB_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int idx, input logic [31:0] pc);
    exp_t x;
    bus.inst_valid   = 1'b1;
    bus.inst_from_if = vecs[idx].inst;
    bus.pc_from_if   = pc;
    x.op = vecs[idx].op;   x.rd = vecs[idx].rd;
    x.rs1 = vecs[idx].rs1; x.rs2 = vecs[idx].rs2;
    x.imm = vecs[idx].imm; x.pc = pc;
    x.tag = tb_tag;        x.is_mem = vecs[idx].is_mem;
    exp_q.push_back(x);
    tb_tag = tb_tag + 4'd1;
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Dispatch monitor: every ROB pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (rst === 1'b1 && bus.rob_send_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL stray_dispatch: got pulse pc=0x%08h, required none", bus.pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        $display("dispatch pc=0x%08h op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h tag=%0d %s",
                 bus.pc_out, bus.op_out, bus.rd_out, bus.rs1_idx, bus.rs2_idx,
                 bus.imm_out, bus.rob_tag, bus.lsb_send_enable ? "LSB" : "RS");
        chk("op_out",  32'(bus.op_out),  32'(mon_e.op));
        chk("rd_out",  32'(bus.rd_out),  32'(mon_e.rd));
        chk("rs1_idx", 32'(bus.rs1_idx), 32'(mon_e.rs1));
        chk("rs2_idx", 32'(bus.rs2_idx), 32'(mon_e.rs2));
        chk("imm_out", bus.imm_out, mon_e.imm);
        chk("pc_out",  bus.pc_out,  mon_e.pc);
        chk("rob_tag", 32'(bus.rob_tag), 32'(mon_e.tag));
        chk("rs_send", 32'(bus.rs_send_enable),  32'(!mon_e.is_mem));
        chk("lsb_send", 32'(bus.lsb_send_enable), 32'(mon_e.is_mem));
      end
    end else if (rst === 1'b1 && (bus.rs_send_enable === 1'b1 || bus.lsb_send_enable === 1'b1)) begin
      n_total++;
      $display("FAIL orphan_send: got rs/lsb pulse without rob pulse, required none");
    end
  end

  initial begin
    vecs[0]  = '{32'h00500093, OP_ADDI,  5'd1,  5'd0, 5'd0, 32'd5,          1'b0};
    vecs[1]  = '{32'h0040A103, OP_LW,    5'd2,  5'd1, 5'd0, 32'd4,          1'b1};
    vecs[2]  = '{32'h00312423, OP_SW,    5'd0,  5'd2, 5'd3, 32'd8,          1'b1};
    vecs[3]  = '{32'h007302B3, OP_ADD,   5'd5,  5'd6, 5'd7, 32'd0,          1'b0};
    vecs[4]  = '{32'h407302B3, OP_SUB,   5'd5,  5'd6, 5'd7, 32'd0,          1'b0};
    vecs[5]  = '{32'h12345537, OP_LUI,   5'd10, 5'd0, 5'd0, 32'h12345000,   1'b0};
    vecs[6]  = '{32'hFE208CE3, OP_BEQ,   5'd0,  5'd1, 5'd2, 32'hFFFFFFF8,   1'b0};
    vecs[7]  = '{32'h010000EF, OP_JAL,   5'd1,  5'd0, 5'd0, 32'd16,         1'b0};
    vecs[8]  = '{32'h00008067, OP_JALR,  5'd0,  5'd1, 5'd0, 32'd0,          1'b0};
    vecs[9]  = '{32'hFFFFFFFF, OP_NOP,   5'd0,  5'd0, 5'd0, 32'd0,          1'b0};
    vecs[10] = '{32'h00001197, OP_AUIPC, 5'd3,  5'd0, 5'd0, 32'h00001000,   1'b0};
    vecs[11] = '{32'h40325213, OP_SRAI,  5'd4,  5'd4, 5'd0, 32'd3,          1'b0};
    vecs[12] = '{32'hFFF04383, OP_LBU,   5'd7,  5'd0, 5'd0, 32'hFFFFFFFF,   1'b1};

    n_pass = 0; n_total = 0; tb_tag = 4'd0;
    rst = 1'b0; rdy = 1'b1;
    bus.inst_valid = 1'b0; bus.inst_from_if = '0; bus.pc_from_if = '0;
    bus.flush = 1'b0; bus.flush_tag = '0;
    bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;

    repeat (3) tick();
    chk("rst_count",    32'(bus.iq_count), 32'd0);
    chk("rst_full",     32'(bus.iq_full), 32'd0);
    chk("rst_rob_send", 32'(bus.rob_send_enable), 32'd0);
    chk("rst_rs_send",  32'(bus.rs_send_enable), 32'd0);
    chk("rst_lsb_send", 32'(bus.lsb_send_enable), 32'd0);
    chk("rst_tag",      32'(bus.rob_tag), 32'd0);
    chk("rst_op",       32'(bus.op_out), 32'd0);
    chk("rst_imm",      bus.imm_out, 32'd0);
    rst = 1'b1;
    tick();

    // ADDI through an empty queue: dispatch latency
    drive(0, 32'h0);
    tick();
    bus.inst_valid = 1'b0;
`ifdef ISSUE_BYPASS_EN
    chk("lat_e0_rob",   32'(bus.rob_send_enable), 32'd1);
    chk("lat_e0_count", 32'(bus.iq_count), 32'd0);
    tick();
    chk("lat_e1_rob",   32'(bus.rob_send_enable), 32'd0);
`else
    chk("lat_e0_rob",   32'(bus.rob_send_enable), 32'd0);
    chk("lat_e0_count", 32'(bus.iq_count), 32'd1);
    tick();
    chk("lat_e1_rob",   32'(bus.rob_send_enable), 32'd1);
    chk("lat_e1_rs",    32'(bus.rs_send_enable), 32'd1);
`endif
    chk("lat_count_after", 32'(bus.iq_count), 32'd0);

    // LW held back by a full LSB for three cycles
    bus.lsb_full = 1'b1;
    drive(1, 32'h4);
    tick();
    bus.inst_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("lsb_stall_rob", 32'(bus.rob_send_enable), 32'd0);
      chk("lsb_stall_lsb", 32'(bus.lsb_send_enable), 32'd0);
      if (k < 2) tick();
    end
    bus.lsb_full = 1'b0;
    tick();
    chk("lsb_release_lsb", 32'(bus.lsb_send_enable), 32'd1);
    chk("lsb_release_rs",  32'(bus.rs_send_enable), 32'd0);

    // Fill to IQ_DEPTH behind a full ROB, then enqueue while the head dispatches
    bus.rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i, 32'h100 + 32'(4 * i));
      tick();
    end
    bus.inst_valid = 1'b0;
    chk("fill_full",  32'(bus.iq_full), 32'd1);
    chk("fill_count", 32'(bus.iq_count), 32'd8);
    bus.rob_full = 1'b0;
    drive(8, 32'h120);
    tick();
    bus.inst_valid = 1'b0;
    chk("full_enq_count", 32'(bus.iq_count), 32'd8);
    chk("full_enq_rob",   32'(bus.rob_send_enable), 32'd1);
    drain();
    chk("fill_drained", 32'(bus.iq_count), 32'd0);

    // Decode table, back to back
    for (int i = 0; i < NVEC; i++) begin
      drive(i, 32'h2000 + 32'(4 * i));
      tick();
    end
    bus.inst_valid = 1'b0;
    drain();

    // Tag wrap: restart at 0 and dispatch 17
    bus.flush = 1'b1; bus.flush_tag = 4'd0;
    tick();
    bus.flush = 1'b0;
    tb_tag = 4'd0;
    for (int k = 0; k < 17; k++) begin
      drive(k % NVEC, 32'h3000 + 32'(4 * k));
      tick();
    end
    bus.inst_valid = 1'b0;
    drain();

    // Flush with 5 queued and a concurrent inst_valid
    bus.rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i + 3, 32'h3800 + 32'(4 * i));
      tick();
    end
    bus.inst_valid = 1'b0;
    chk("pre_flush_count", 32'(bus.iq_count), 32'd5);
    exp_q.delete();
    bus.flush = 1'b1; bus.flush_tag = 4'd9; bus.rob_full = 1'b0;
    bus.inst_valid = 1'b1; bus.inst_from_if = vecs[0].inst; bus.pc_from_if = 32'h3900;
    tick();
    bus.flush = 1'b0; bus.inst_valid = 1'b0;
    tb_tag = 4'd9;
    chk("flush_count", 32'(bus.iq_count), 32'd0);
    chk("flush_rob",   32'(bus.rob_send_enable), 32'd0);
    tick();
    chk("flush_drop_count", 32'(bus.iq_count), 32'd0);
    chk("flush_drop_rob",   32'(bus.rob_send_enable), 32'd0);
    drive(3, 32'h4000);
    tick();
    bus.inst_valid = 1'b0;
    drain();

    // rdy low freezes the queue
    bus.rob_full = 1'b1;
    drive(5, 32'h4800);
    tick();
    bus.inst_valid = 1'b0;
    rdy = 1'b0; bus.rob_full = 1'b0;
    tick(); tick();
    chk("frozen_count", 32'(bus.iq_count), 32'd1);
    chk("frozen_rob",   32'(bus.rob_send_enable), 32'd0);
    rdy = 1'b1;
    drain();

    // Reset in the middle of a stream
    bus.rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i, 32'h5000 + 32'(4 * i));
      tick();
    end
    bus.inst_valid = 1'b0;
    chk("pre_rst_count", 32'(bus.iq_count), 32'd3);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.iq_count), 32'd0);
    exp_q.delete();
    tb_tag = 4'd0;
    bus.rob_full = 1'b0;
    tick();
    chk("rst_hold_rob", 32'(bus.rob_send_enable), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(bus.iq_count), 32'd0);
    chk("post_rst_rob",   32'(bus.rob_send_enable), 32'd0);
    drive(6, 32'h6000);
    tick();
    bus.inst_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
